multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Control FSM for the multicycle RV32I core.
//  Sequences fetch/decode/execute/memory/writeback per instruction.
//  Drives imm_sel to the sign_extend unit (0=I,1=S,2=B,3=U,4=J).
//  Also drives PC/IR/regfile/memory enables and ALU operand selects.
// PARAMETERS
//  MEM_TIMEOUT  default 255  max cycles waiting on mem_ready before mem_err; 0 disables
// PORTS
//  clk           in   1  rising-edge clock
//  rst           in   1  synchronous reset, active-high
//  opcode        in   7  IR[6:0], valid from DECODE onward
//  funct3        in   3  IR[14:12]
//  branch_taken  in   1  comparator result for current funct3, valid in BRANCH
//  mem_ready     in   1  memory completes access this cycle
//  imm_sel       out  3  sign_extend select: 0 I, 1 S, 2 B, 3 U, 4 J
//  pc_write      out  1  load PC from result mux
//  ir_write      out  1  load IR and old_pc from memory data / PC
//  mem_req       out  1  memory access request, held until mem_ready
//  mem_we        out  1  store when mem_req=1
//  adr_src       out  1  0=PC, 1=ALU out reg (memory address mux)
//  reg_write     out  1  register file write enable
//  alu_src_a     out  2  0=PC, 1=old_pc, 2=rs1, 3=zero
//  alu_src_b     out  2  0=rs2, 1=imm, 2=const 4
//  alu_op        out  2  0=add, 1=sub, 2=funct-decoded
//  result_src    out  2  0=ALU out reg, 1=mem data reg, 2=ALU result
//  illegal_instr out  1  one-cycle pulse on unsupported opcode
//  mem_err       out  1  one-cycle pulse on memory timeout
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, all outputs 0. Reset wins over all
//    inputs, including mid-access (mem_req drops the cycle after rst).
//  - States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I,
//    ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC.
//  - FETCH: mem_req=1, adr_src=0, a=PC, b=4, add.
//    Stay until mem_ready. On the mem_ready cycle: ir_write=1, pc_write=1
//    (result_src=2), -> DECODE.
//  - DECODE: a=old_pc, b=imm, add, imm_sel=B; branch target goes to ALU out reg.
//    Next state by opcode:
//      03 -> MEM_ADR, 23 -> MEM_ADR, 33 -> EXEC_R, 13 -> EXEC_I,
//      63 -> BRANCH, 6F -> JAL, 67 -> JALR, 37 -> LUI, 17 -> AUIPC.
//    Any other opcode: illegal_instr=1 for this cycle, -> FETCH; PC already advanced.
//  - MEM_ADR: a=rs1, b=imm, add; imm_sel=S if opcode 23 else I.
//    -> MEM_WR if opcode 23 else MEM_RD.
//  - MEM_RD: mem_req=1, adr_src=1; wait for mem_ready, then -> MEM_WB.
//  - MEM_WB: reg_write=1, result_src=1 -> FETCH.
//  - MEM_WR: mem_req=1, mem_we=1, adr_src=1; on mem_ready -> FETCH.
//  - EXEC_R: a=rs1, b=rs2, alu_op=2 -> ALU_WB.
//  - EXEC_I: a=rs1, b=imm, imm_sel=I, alu_op=2 -> ALU_WB.
//  - ALU_WB: reg_write=1, result_src=0 -> FETCH.
//  - BRANCH: a=rs1, b=rs2, alu_op=1; pc_write=branch_taken, result_src=0
//    (target computed in DECODE) -> FETCH. Mealy on branch_taken.
//  - JAL: a=old_pc, b=imm, imm_sel=J, add; pc_write=1, result_src=2;
//    reg_write=1 with rd=old_pc+4 supplied from ALU out reg -> FETCH.
//  - JALR: a=rs1, b=imm, imm_sel=I; pc_write=1, result_src=2, reg_write=1
//    from ALU out reg -> FETCH.
//  - LUI: a=zero, b=imm, imm_sel=U, add -> ALU_WB.
//  - AUIPC: a=old_pc, b=imm, imm_sel=U, add -> ALU_WB.
//  - mem_ready outside a mem_req state: ignored.
//  - Wait counter: counts consecutive mem_req cycles without mem_ready.
//    When it reaches MEM_TIMEOUT: mem_err=1 pulse, mem_req drops, -> FETCH,
//    counter cleared. Counter also clears on mem_ready.
//  - Latency (zero-wait memory): load 5, store 4, R/I/LUI/AUIPC 4,
//    branch/jal/jalr 3 cycles.
// TESTING
//  - rst=1 during FETCH with mem_req=1 -> next cycle all outputs 0, state FETCH.
//  - addi x1,x0,5 (0x00500093), mem_ready always 1 -> ir_write@c0, EXEC_I
//    imm_sel=0@c2, reg_write@c3; next fetch @c4.
//  - sw (opcode 23), mem_ready low for 3 cycles in MEM_WR -> imm_sel=1 in MEM_ADR;
//    mem_we=1 held for 4 cycles, then FETCH.
//  - beq (opcode 63) with branch_taken=0 then =1 -> DECODE imm_sel=2;
//    pc_write in BRANCH equals branch_taken.
//  - jal (6F) then lui (37) -> JAL: imm_sel=4, pc_write=reg_write=1;
//    LUI: imm_sel=3, alu_src_a=3.
//  - opcode 7F -> illegal_instr pulse in DECODE, back to FETCH.
//    MEM_TIMEOUT=4 with mem_ready held 0 -> mem_err on 4th wait cycle.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Control sequencer for the multicycle RV32I core. Steps each instruction
//   through fetch / decode / execute / memory / writeback and drives the
//   datapath enables, operand selects and the sign_extend immediate select.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode, funct3      instruction fields from IR (valid from DECODE on)
//   branch_taken        comparator result, consumed in BRANCH
//   mem_ready           memory completes the requested access this cycle
//   imm_sel             0 I, 1 S, 2 B, 3 U, 4 J
//   pc_write, ir_write  PC load / IR+old_pc load
//   mem_req, mem_we     memory request (held until mem_ready) and store flag
//   adr_src             memory address: 0 PC, 1 ALU out reg
//   reg_write           register file write enable
//   alu_src_a           0 PC, 1 old_pc, 2 rs1, 3 zero
//   alu_src_b           0 rs2, 1 imm, 2 const 4
//   alu_op              0 add, 1 sub, 2 funct-decoded
//   result_src          0 ALU out reg, 1 mem data reg, 2 ALU result
//   illegal_instr       one-cycle pulse on an unsupported opcode
//   mem_err             one-cycle pulse when a memory access times out
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic [2:0] imm_sel,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal_instr,
    output logic       mem_err
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    // High for the first cycle after reset: every output is held at zero so
    // an access interrupted by reset really drops before FETCH restarts.
    logic            init_reg;
    logic            in_mem_state;
    logic            timeout;

    // funct3 is consumed by the ALU decoder, not by the sequencer.
    logic unused_funct3;
    assign unused_funct3 = ^funct3;

    assign in_mem_state = !init_reg &&
                          (state_reg == S_FETCH || state_reg == S_MEM_RD || state_reg == S_MEM_WR);
    // The timeout cycle itself withdraws the request, so mem_ready is ignored there.
    assign timeout = in_mem_state && (MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            init_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            init_reg     <= 1'b0;
        end
    end

    // Wait counter: consecutive requesting cycles without mem_ready.
    always_comb begin
        wait_cnt_next = '0;
        if (in_mem_state && !timeout && !mem_ready && (MEM_TIMEOUT != 0))
            wait_cnt_next = wait_cnt_reg + CW'(1);
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (init_reg || timeout) begin
            state_next = S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:   if (mem_ready) state_next = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                        OP_RTYPE:          state_next = S_EXEC_R;
                        OP_ITYPE:          state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default:           state_next = S_FETCH;
                    endcase
                end
                S_MEM_ADR: state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:  if (mem_ready) state_next = S_MEM_WB;
                S_MEM_WR:  if (mem_ready) state_next = S_FETCH;
                S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_next = S_ALU_WB;
                default:   state_next = S_FETCH;
            endcase
        end
    end

    // Output logic
    always_comb begin
        imm_sel       = 3'd0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'd0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        result_src    = 2'd0;
        illegal_instr = 1'b0;
        mem_err       = 1'b0;
        if (timeout) begin
            mem_err = 1'b1;
        end else if (!init_reg) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'd2;
                    result_src = 2'd2;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    // Branch target old_pc + immB lands in the ALU out reg.
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    imm_sel   = 3'd2;
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_instr = 1'b0;
                        default:                           illegal_instr = 1'b1;
                    endcase
                end
                S_MEM_ADR: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    imm_sel   = (opcode == OP_STORE) ? 3'd1 : 3'd0;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = 2'd1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'd2;
                    alu_op    = 2'd2;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    alu_op    = 2'd2;
                end
                S_ALU_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'd2;
                    alu_op    = 2'd1;
                    pc_write  = branch_taken;
                end
                S_JAL: begin
                    alu_src_a  = 2'd1;
                    alu_src_b  = 2'd1;
                    imm_sel    = 3'd4;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'd2;
                end
                S_JALR: begin
                    alu_src_a  = 2'd2;
                    alu_src_b  = 2'd1;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'd2;
                end
                S_LUI: begin
                    alu_src_a = 2'd3;
                    alu_src_b = 2'd1;
                    imm_sel   = 3'd3;
                end
                S_AUIPC: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    imm_sel   = 3'd3;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Table-driven check of the control sequencer: each table row is one clock
//   cycle of inputs plus the full expected output word. Hand-written sequences
//   cover reset during an access and the memory timeout (second instance with
//   MEM_TIMEOUT=4).
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'h00;
    logic [2:0] funct3 = 3'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_ready_to = 1'b1;

    logic [2:0] imm_sel;
    logic       pc_write, ir_write, mem_req, mem_we, adr_src, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       illegal_instr, mem_err;

    logic [2:0] t_imm_sel;
    logic       t_pc_write, t_ir_write, t_mem_req, t_mem_we, t_adr_src, t_reg_write;
    logic [1:0] t_alu_src_a, t_alu_src_b, t_alu_op, t_result_src;
    logic       t_illegal_instr, t_mem_err;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .imm_sel(imm_sel), .pc_write(pc_write), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src),
        .illegal_instr(illegal_instr), .mem_err(mem_err)
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready_to),
        .imm_sel(t_imm_sel), .pc_write(t_pc_write), .ir_write(t_ir_write),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .adr_src(t_adr_src),
        .reg_write(t_reg_write), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
        .alu_op(t_alu_op), .result_src(t_result_src),
        .illegal_instr(t_illegal_instr), .mem_err(t_mem_err)
    );

    // {imm_sel, pc_write, ir_write, mem_req, mem_we, adr_src, reg_write,
    //  alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, mem_err}
    logic [18:0] act_vec;
    assign act_vec = {imm_sel, pc_write, ir_write, mem_req, mem_we, adr_src, reg_write,
                      alu_src_a, alu_src_b, alu_op, result_src, illegal_instr, mem_err};

    typedef struct {
        logic [6:0]  opc;
        logic        bt;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [18:0] e(input int imm, input int pcw, input int irw,
                                      input int req, input int we, input int adr,
                                      input int rw, input int a, input int b,
                                      input int op, input int rs, input int ill,
                                      input int err);
        return {imm[2:0], pcw[0], irw[0], req[0], we[0], adr[0], rw[0],
                a[1:0], b[1:0], op[1:0], rs[1:0], ill[0], err[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] opc, input logic bt, input logic rdy,
                       input logic [18:0] exp);
        vec_t v;
        v.opc = opc; v.bt = bt; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [18:0] zero_o, f_wait, f_go, dec, alu_wb;
        zero_o = '0;
        f_wait = e(0,0,0,1,0,0,0, 0,2,0,2, 0,0);
        f_go   = e(0,1,1,1,0,0,0, 0,2,0,2, 0,0);
        dec    = e(2,0,0,0,0,0,0, 1,1,0,0, 0,0);
        alu_wb = e(0,0,0,0,0,0,1, 0,0,0,0, 0,0);

        // row 0: first cycle after reset (reset lands mid-fetch below)
        add(7'h13, 0, 1, zero_o);
        // addi x1,x0,5
        add(7'h13, 0, 1, f_go);
        add(7'h13, 0, 1, dec);
        add(7'h13, 0, 1, e(0,0,0,0,0,0,0, 2,1,2,0, 0,0));   // EXEC_I
        add(7'h13, 0, 1, alu_wb);
        // sw with three wait cycles
        add(7'h23, 0, 1, f_go);
        add(7'h23, 0, 1, dec);
        add(7'h23, 0, 1, e(1,0,0,0,0,0,0, 2,1,0,0, 0,0));   // MEM_ADR store
        for (int i = 0; i < 3; i++)
            add(7'h23, 0, 0, e(0,0,0,1,1,1,0, 0,0,0,0, 0,0));
        add(7'h23, 0, 1, e(0,0,0,1,1,1,0, 0,0,0,0, 0,0));
        // lw with one fetch wait
        add(7'h03, 0, 0, f_wait);
        add(7'h03, 0, 1, f_go);
        add(7'h03, 0, 1, dec);
        add(7'h03, 0, 1, e(0,0,0,0,0,0,0, 2,1,0,0, 0,0));   // MEM_ADR load
        add(7'h03, 0, 1, e(0,0,0,1,0,1,0, 0,0,0,0, 0,0));   // MEM_RD
        add(7'h03, 0, 1, e(0,0,0,0,0,0,1, 0,0,0,1, 0,0));   // MEM_WB
        // beq not taken, then taken
        add(7'h63, 0, 1, f_go);
        add(7'h63, 0, 1, dec);
        add(7'h63, 0, 1, e(0,0,0,0,0,0,0, 2,0,1,0, 0,0));
        add(7'h63, 1, 1, f_go);
        add(7'h63, 1, 1, dec);
        add(7'h63, 1, 1, e(0,1,0,0,0,0,0, 2,0,1,0, 0,0));
        // jal
        add(7'h6F, 0, 1, f_go);
        add(7'h6F, 0, 1, dec);
        add(7'h6F, 0, 1, e(4,1,0,0,0,0,1, 1,1,0,2, 0,0));
        // lui
        add(7'h37, 0, 1, f_go);
        add(7'h37, 0, 1, dec);
        add(7'h37, 0, 1, e(3,0,0,0,0,0,0, 3,1,0,0, 0,0));
        add(7'h37, 0, 1, alu_wb);
        // illegal opcode
        add(7'h7F, 0, 1, f_go);
        add(7'h7F, 0, 1, e(2,0,0,0,0,0,0, 1,1,0,0, 1,0));
        // R-type
        add(7'h33, 0, 1, f_go);
        add(7'h33, 0, 1, dec);
        add(7'h33, 0, 1, e(0,0,0,0,0,0,0, 2,0,2,0, 0,0));
        add(7'h33, 0, 1, alu_wb);
        // jalr
        add(7'h67, 0, 1, f_go);
        add(7'h67, 0, 1, dec);
        add(7'h67, 0, 1, e(0,1,0,0,0,0,1, 2,1,0,2, 0,0));
        // auipc
        add(7'h17, 0, 1, f_go);
        add(7'h17, 0, 1, dec);
        add(7'h17, 0, 1, e(3,0,0,0,0,0,0, 1,1,0,0, 0,0));
        add(7'h17, 0, 1, alu_wb);
        add(7'h13, 0, 0, f_wait);

        // Reset, then interrupt a pending fetch with reset.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1 chk("post_reset_idle", {13'd0, act_vec}, {13'd0, zero_o});
        @(negedge clk);
        #1 chk("fetch_req_pending", {13'd0, act_vec}, {13'd0, f_wait});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Row 0 is checked on this same negedge: outputs must already be zero.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            opcode       = vecs[i].opc;
            branch_taken = vecs[i].bt;
            mem_ready    = vecs[i].rdy;
            #1 chk($sformatf("row%0d", i), {13'd0, act_vec}, {13'd0, vecs[i].exp});
        end

        // Memory timeout on the MEM_TIMEOUT=4 instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_ready_to = 1'b0;
        #1 chk("to_idle_req", {31'd0, t_mem_req}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_req_c%0d", k), {31'd0, t_mem_req}, (k == 4) ? 32'd0 : 32'd1);
            chk($sformatf("to_err_c%0d", k), {31'd0, t_mem_err}, (k == 4) ? 32'd1 : 32'd0);
        end
        // Default instance keeps waiting without error.
        chk("no_timeout_default", {31'd0, mem_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
